// File: rtl/prefetch_fetcher_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the prefetching instruction fetcher.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/prefetch_fetcher_if.sv
// ============================================================================
// Module   : prefetch_fetcher_if
// Purpose  : Memory-side and decoder-side signal bundle of the fetcher.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface prefetch_fetcher_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_valid;
  logic            mem_instr;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetcher_valid;
  logic            decoder_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] fetcher_pc;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  redirect_valid, redirect_pc,
    output fetcher_valid, instr, fetcher_pc,
    input  decoder_ready
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output redirect_valid, redirect_pc,
    input  fetcher_valid, instr, fetcher_pc,
    output decoder_ready
  );
endinterface

`default_nettype wire

// File: rtl/prefetch_fetcher_fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Circular prefetch buffer of {pc, instr} entries with flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         flush,
  input  wire logic         push,
  input  fetch_entry_t      push_entry,
  input  wire logic         pop,
  output fetch_entry_t      head,
  output logic [CNT_W-1:0]  count
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both push and pop; a full queue still accepts a push when
  // the head leaves in the same cycle.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && !flush && (count_q != '0);
    do_push  = push && !flush && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/prefetch_fetcher.sv
// ============================================================================
// Module   : prefetch_fetcher
// Purpose  : Sequential instruction prefetcher with redirect, feeding a decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prefetch_fetcher
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input wire logic            clk,
  input wire logic            reset,
  prefetch_fetcher_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic             mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;

  logic [XLEN-1:0]  redir_pc;
  logic             q_push;
  logic             q_pop;
  logic             q_valid;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] cnt_after_pop;
  logic             room_after;
  fetch_entry_t     q_head;
  fetch_entry_t     q_in;

  assign redir_pc      = bus.redirect_pc & ~XLEN'(3);
  assign q_valid       = (q_count != '0);
  assign q_pop         = q_valid && bus.decoder_ready;
  assign cnt_after_pop = q_count - CNT_W'(q_pop);
  // The next request needs a free slot beyond the one this handshake fills.
  assign room_after    = (cnt_after_pop < CNT_W'(DEPTH - 1));
  assign q_in          = '{pc: fetch_pc_q, instr: bus.mem_rdata};

  // In REQ, mem_addr always equals fetch_pc; in DRAIN, mem_addr is the stale
  // in-flight address while fetch_pc already holds the redirect target.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    fetch_pc_d  = fetch_pc_q;
    q_push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = redir_pc;
        end
        if (bus.redirect_valid || (q_count < CNT_W'(DEPTH))) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = fetch_pc_d;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = redir_pc;
          if (bus.mem_ready) begin
            mem_addr_d = redir_pc;
          end else begin
            state_d = DRAIN;
          end
        end else if (bus.mem_ready) begin
          q_push     = 1'b1;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          mem_addr_d = fetch_pc_q + XLEN'(4);
          if (!room_after) begin
            mem_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      DRAIN: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = redir_pc;
        end
        if (bus.mem_ready) begin
          mem_addr_d = fetch_pc_d;
          state_d    = REQ;
        end
      end
      default: begin
        mem_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      fetch_pc_q  <= fetch_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.redirect_valid),
    .push       (q_push),
    .push_entry (q_in),
    .pop        (q_pop),
    .head       (q_head),
    .count      (q_count)
  );

  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_instr     = mem_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = '0;
  assign bus.mem_wstrb     = '0;
  assign bus.fetcher_valid = q_valid;
  assign bus.instr         = q_valid ? q_head.instr : '0;
  assign bus.fetcher_pc    = q_valid ? q_head.pc    : '0;

endmodule

`default_nettype wire

// File: tb/tb_prefetch_fetcher.sv
// ============================================================================
// Module   : tb_prefetch_fetcher
// Purpose  : Self-checking bench for prefetch_fetcher against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_prefetch_fetcher;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prefetch_fetcher_if #(.XLEN(32)) bus ();

  prefetch_fetcher #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .XLEN     (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic        stale;
  int          idle_run;
  int          hs_count;
  logic [31:0] last_hs_addr;

  // Memory contents: every word is a fixed function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, check at next negedge.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic mr, input logic dr);
    logic        hs, pop, pend;
    logic [31:0] pre_addr, pc;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.mem_ready      = mr;
    bus.decoder_ready  = dr;
    bus.mem_rdata      = mem_word(bus.mem_addr);
    #1;
    hs       = bus.mem_valid && mr;
    pop      = bus.fetcher_valid && dr;
    pend     = bus.mem_valid && !mr;
    pre_addr = bus.mem_addr;
    @(posedge clk);
    if (hs) begin
      hs_count++;
      last_hs_addr = pre_addr;
    end
    if (pop && !rv && exp_q.size() != 0) void'(exp_q.pop_front());
    if (hs && !stale && !rv) begin
      pc = exp_fetch;
      check("fetch_addr", pre_addr, pc);
      exp_q.push_back(pc);
      exp_fetch = pc + 32'd4;
    end
    if (rv) begin
      exp_q.delete();
      exp_fetch = rpc & 32'hFFFF_FFFC;
      stale     = pend;
    end else if (hs) begin
      stale = 1'b0;
    end
    @(negedge clk);
    if (pend) begin
      check("hold_valid", bus.mem_valid, 32'd1);
      check("hold_addr", bus.mem_addr, pre_addr);
    end
    check("fetcher_valid", bus.fetcher_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("fetcher_pc", bus.fetcher_pc, exp_q[0]);
      check("instr", bus.instr, mem_word(exp_q[0]));
    end
    if (bus.mem_valid) begin
      check("mem_instr", bus.mem_instr, 32'd1);
      check("slot_reserved", exp_q.size() < DEPTH, 32'd1);
    end
    check("wdata_wstrb", bus.mem_wdata | {28'd0, bus.mem_wstrb}, 32'd0);
    idle_run = (!bus.mem_valid && exp_q.size() < DEPTH) ? idle_run + 1 : 0;
    check("idle_stall", idle_run > 1, 32'd0);
  endtask

  task automatic apply_reset();
    reset              = 1'b1;
    bus.mem_ready      = 1'b0;
    bus.mem_rdata      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.decoder_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_valid", bus.mem_valid, 32'd0);
    check("rst_mem_addr", bus.mem_addr, RESET_PC);
    check("rst_fetcher_valid", bus.fetcher_valid, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_fetcher_pc", bus.fetcher_pc, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_fetch = RESET_PC;
    stale     = 1'b0;
    idle_run  = 0;
    hs_count  = 0;
  endtask

  initial begin
    apply_reset();

    // Streaming at full rate
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    check("t1_addr0", bus.mem_addr, 32'h100);
    check("t1_valid0", bus.mem_valid, 32'd1);
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    check("t1_addr1", bus.mem_addr, 32'h104);
    check("t1_fv", bus.fetcher_valid, 32'd1);
    check("t1_pc", bus.fetcher_pc, 32'h100);
    check("t1_instr", bus.instr, mem_word(32'h100));
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    check("t1_addr2", bus.mem_addr, 32'h108);

    // Fill with a stalled decoder, then free one slot
    apply_reset();
    repeat (10) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("t2_hs_count", hs_count, 32'd4);
    check("t2_idle", bus.mem_valid, 32'd0);
    check("t2_head", bus.fetcher_pc, 32'h100);
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    check("t2_head_adv", bus.fetcher_pc, 32'h104);
    hs_count = 0;
    repeat (6) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("t2_refill_count", hs_count, 32'd1);
    check("t2_refill_addr", last_hs_addr, 32'h110);

    // Redirect while the memory is stalled
    apply_reset();
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 32'h200, 1'b0, 1'b0);
    check("t3_hold_valid", bus.mem_valid, 32'd1);
    check("t3_hold_addr", bus.mem_addr, 32'h104);
    check("t3_flushed", bus.fetcher_valid, 32'd0);
    repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b0);
    check("t3_still_addr", bus.mem_addr, 32'h104);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("t3_new_addr", bus.mem_addr, 32'h200);
    check("t3_discarded", bus.fetcher_valid, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("t3_target_pc", bus.fetcher_pc, 32'h200);

    // Redirect, handshake and pop in the same cycle with a misaligned target
    apply_reset();
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 32'h202, 1'b1, 1'b1);
    check("t4_empty", bus.fetcher_valid, 32'd0);
    check("t4_addr", bus.mem_addr, 32'h200);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    check("t4_no_entry", bus.fetcher_valid, 32'd0);

    // Asynchronous reset in the middle of a request
    apply_reset();
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t5_async_mv", bus.mem_valid, 32'd0);
    check("t5_async_fv", bus.fetcher_valid, 32'd0);
    apply_reset();
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    check("t5_first_addr", bus.mem_addr, RESET_PC);

    // Address wrap at the top of the address space
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    check("t6_addr_top", bus.mem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    check("t6_addr_wrap", bus.mem_addr, 32'h0);
    check("t6_pc_top", bus.fetcher_pc, 32'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    check("t6_pc_wrap", bus.fetcher_pc, 32'h0);

    // Random traffic against the model
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 5, $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
